// File: rtl/rf_pkg.sv
// Shared definitions for the rf write-port controller: size defaults, FSM states, requester ids.
package rf_pkg;

  localparam int NREG_DEFAULT = 32;
  localparam int AW_DEFAULT   = 5;
  localparam int DW_DEFAULT   = 32;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_t;

  // Requester ids, as held in the round-robin pointer and reported on grant_b.
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

endpackage

// File: rtl/rf_wr_arbiter_rr_arb2.sv
// Two-way round-robin picker: purely combinational, one-hot grant.
// On a tie the requester that was not served last wins; the pointer lives in the caller.
module rr_arb2
  import rf_pkg::*;
(
  input  logic req_a,
  input  logic req_b,
  input  logic last,
  output logic gnt_a,
  output logic gnt_b
);

  assign gnt_a = req_a && (!req_b || (last == SRC_B));
  assign gnt_b = req_b && (!req_a || (last == SRC_A));

endmodule

// File: rtl/rf_wr_arbiter.sv
// rf write-port controller: clears all NREG registers after reset, then round-robins A/B writes.
// An accept at edge N drives wReg/data/RegWrite after edge N; both readies are held low while clearing.
module rf_wr_arbiter
  import rf_pkg::*;
#(
  parameter int NREG = NREG_DEFAULT,
  parameter int AW   = AW_DEFAULT,
  parameter int DW   = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_reg,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_reg,
  input  logic [DW-1:0] b_data,
  output logic [AW-1:0] wReg,
  output logic [DW-1:0] data,
  output logic          RegWrite,
  output logic          grant_b,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_REG = AW'(NREG - 1);

  state_t        state;
  logic [AW-1:0] clrCnt;
  logic          last;
  logic          gntA;
  logic          gntB;

  rr_arb2 uArb (
    .req_a (a_valid),
    .req_b (b_valid),
    .last  (last),
    .gnt_a (gntA),
    .gnt_b (gntB)
  );

  // Readies are gated by state so nothing is accepted while the clear owns the port.
  assign busy    = (state == ST_CLEAR);
  assign a_ready = (state == ST_RUN) && gntA;
  assign b_ready = (state == ST_RUN) && gntB;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_CLEAR;
      clrCnt   <= '0;
      last     <= SRC_B;
      wReg     <= '0;
      data     <= '0;
      RegWrite <= 1'b0;
      grant_b  <= 1'b0;
    end else begin
      case (state)
        ST_CLEAR: begin
          wReg     <= clrCnt;
          data     <= '0;
          RegWrite <= 1'b1;
          grant_b  <= 1'b0;
          clrCnt   <= clrCnt + 1'b1;
          if (clrCnt == LAST_REG) begin
            state  <= ST_RUN;
            clrCnt <= '0;
          end
        end
        ST_RUN: begin
          if (a_ready) begin
            wReg     <= a_reg;
            data     <= a_data;
            RegWrite <= 1'b1;
            grant_b  <= 1'b0;
            last     <= SRC_A;
          end else if (b_ready) begin
            wReg     <= b_reg;
            data     <= b_data;
            RegWrite <= 1'b1;
            grant_b  <= 1'b1;
            last     <= SRC_B;
          end else begin
            // Idle: drop the strobe, keep wReg/data as last written.
            RegWrite <= 1'b0;
            grant_b  <= 1'b0;
          end
        end
        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Self-checking bench for rf_wr_arbiter with a stub rf and a queue-free reference model of rf contents.
module tb_rf_wr_arbiter;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          a_valid, b_valid;
  logic          a_ready, b_ready;
  logic [AW-1:0] a_reg, b_reg;
  logic [DW-1:0] a_data, b_data;
  logic [AW-1:0] wReg;
  logic [DW-1:0] data;
  logic          RegWrite, grant_b, busy;

  int nChecks = 0;
  int nPass   = 0;
  int nFail   = 0;

  // Reference model state
  int            lastWin;            // 0 = A served last, 1 = B served last
  logic [DW-1:0] refMem [NREG];
  logic [AW-1:0] expReg;
  logic [DW-1:0] expData;
  int            grantLog [$];

  // Stub of the register file, written only through the DUT's write port.
  logic [DW-1:0] rfArr [NREG];

  rf_wr_arbiter #(.NREG(NREG), .AW(AW), .DW(DW)) dut (
    .clk      (clk),
    .reset    (reset),
    .a_valid  (a_valid),
    .a_ready  (a_ready),
    .a_reg    (a_reg),
    .a_data   (a_data),
    .b_valid  (b_valid),
    .b_ready  (b_ready),
    .b_reg    (b_reg),
    .b_data   (b_data),
    .wReg     (wReg),
    .data     (data),
    .RegWrite (RegWrite),
    .grant_b  (grant_b),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (RegWrite === 1'b1) rfArr[wReg] <= data;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", nChecks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nChecks++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic checkResetValues();
    check("rst_RegWrite", 64'(RegWrite), 64'(0));
    check("rst_wReg",     64'(wReg),     64'(0));
    check("rst_data",     64'(data),     64'(0));
    check("rst_grant_b",  64'(grant_b),  64'(0));
    check("rst_busy",     64'(busy),     64'(1));
    check("rst_a_ready",  64'(a_ready),  64'(0));
    check("rst_b_ready",  64'(b_ready),  64'(0));
  endtask

  // Reset wipes the model: rf will be cleared, pointer favours A first.
  task automatic modelReset();
    lastWin = 1;
    expReg  = '0;
    expData = '0;
  endtask

  // Expects NREG clear writes 0..NREG-1, one per edge, starting at the next edge.
  task automatic doClear();
    for (int i = 0; i < NREG; i++) begin
      @(posedge clk); #1;
      check("clr_RegWrite", 64'(RegWrite), 64'(1));
      check("clr_wReg",     64'(wReg),     64'(i));
      check("clr_data",     64'(data),     64'(0));
      check("clr_grant_b",  64'(grant_b),  64'(0));
      check("clr_busy",     64'(busy),     64'(i < NREG - 1));
      if (i < NREG - 1) begin
        check("clr_a_ready", 64'(a_ready), 64'(0));
        check("clr_b_ready", 64'(b_ready), 64'(0));
      end
      refMem[i] = '0;
    end
    expReg  = AW'(NREG - 1);
    expData = '0;
  endtask

  // One RUN cycle: predict the winner, check readies mid-cycle, check the write port after the edge.
  task automatic runCycle();
    int win;
    @(negedge clk);
    if (a_valid && b_valid) win = 1 - lastWin;
    else if (a_valid)       win = 0;
    else if (b_valid)       win = 1;
    else                    win = -1;
    check("a_ready", 64'(a_ready), 64'(win == 0));
    check("b_ready", 64'(b_ready), 64'(win == 1));
    check("busy",    64'(busy),    64'(0));
    @(posedge clk); #1;
    if (win == 0) begin
      expReg = a_reg; expData = a_data; a_valid = 1'b0;
    end else if (win == 1) begin
      expReg = b_reg; expData = b_data; b_valid = 1'b0;
    end
    if (win >= 0) begin
      refMem[expReg] = expData;
      lastWin = win;
      grantLog.push_back(win);
    end
    check("RegWrite", 64'(RegWrite), 64'(win >= 0));
    check("grant_b",  64'(grant_b),  64'(win == 1));
    check("wReg",     64'(wReg),     64'(expReg));
    check("data",     64'(data),     64'(expData));
  endtask

  // Call only after an idle cycle so the last accepted write has landed.
  task automatic checkRf(input string tag);
    for (int i = 0; i < NREG; i++) check(tag, 64'(rfArr[i]), 64'(refMem[i]));
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) begin
      rfArr[i]  = 32'hDEADBEEF;
      refMem[i] = 32'hDEADBEEF;
    end
    a_valid = 1'b0; b_valid = 1'b0;
    a_reg = '0; b_reg = '0; a_data = '0; b_data = '0;
    modelReset();

    // Power-on reset, 6 ns low; A raises a request as reset releases.
    reset = 1'b0;
    #3;
    checkResetValues();
    #3;
    reset = 1'b1;
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h77;
    doClear();
    runCycle();                     // A's request goes on the first RUN cycle
    runCycle();                     // idle; clear and reg 7 both landed
    checkRf("rf_after_clear");
    check("rf_reg7", 64'(rfArr[7]), 64'h77);

    // Single requester: A writes k*10 to reg k.
    for (int k = 1; k < NREG; k++) begin
      a_valid = 1'b1; a_reg = AW'(k); a_data = DW'(k * 10);
      runCycle();
    end
    runCycle();
    checkRf("rf_single");
    check("rf_reg5", 64'(rfArr[5]), 64'(50));

    // Contention on reg 3: both always valid, grants must alternate.
    grantLog.delete();
    for (int n = 0; n < 8; n++) begin
      if (!a_valid) begin a_valid = 1'b1; a_reg = 5'd3; a_data = 32'd111; end
      if (!b_valid) begin b_valid = 1'b1; b_reg = 5'd3; b_data = 32'd222; end
      runCycle();
    end
    for (int n = 1; n < grantLog.size(); n++)
      check("alternate", 64'(grantLog[n]), 64'(1 - grantLog[n-1]));
    while (a_valid || b_valid) runCycle();
    runCycle();
    checkRf("rf_contention");

    // Randomized traffic; each requester holds its request until accepted.
    for (int n = 0; n < 300; n++) begin
      if (!a_valid && $urandom_range(0, 1) == 1) begin
        a_valid = 1'b1; a_reg = AW'($urandom_range(0, NREG - 1)); a_data = $urandom;
      end
      if (!b_valid && $urandom_range(0, 2) != 0) begin
        b_valid = 1'b1; b_reg = AW'($urandom_range(0, NREG - 1)); b_data = $urandom;
      end
      runCycle();
    end
    for (int n = 0; n < 4 && (a_valid || b_valid); n++) runCycle();
    check("drained", 64'(a_valid || b_valid), 64'(0));
    runCycle();
    checkRf("rf_random");

    // Ten more writes, then reset lands while the tenth is on the port.
    for (int k = 0; k < 10; k++) begin
      a_valid = 1'b1; a_reg = AW'(k + 2); a_data = 32'hA000 + DW'(k);
      runCycle();
    end
    check("pre_rst_RegWrite", 64'(RegWrite), 64'(1));
    #1;
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0;
    #1;
    checkResetValues();
    #6;
    reset = 1'b1;
    modelReset();
    doClear();
    runCycle();
    checkRf("rf_after_reclear");

    // Brief traffic after the second clear, A should win the first tie again.
    grantLog.delete();
    a_valid = 1'b1; a_reg = 5'd1; a_data = 32'h1111;
    b_valid = 1'b1; b_reg = 5'd2; b_data = 32'h2222;
    runCycle();
    runCycle();
    check("first_tie_A", 64'(grantLog[0]), 64'(0));
    runCycle();
    checkRf("rf_final");

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/rf_wr_arbiter.md
# rf_wr_arbiter

Write-port controller for the 32x32 register file `rf`. It clears every register to zero after reset, then shares the single write port (`wReg`, `data`, `RegWrite`) between two writeback requesters, A and B, using valid/ready handshakes and round-robin arbitration. It sits between the writeback stage(s) and `rf`; the read ports of `rf` are not touched.

## Interface
Parameters:
- `NREG`, default 32: number of registers cleared and addressable.
- `AW`, default 5: register-number width (`NREG` <= 2**`AW`).
- `DW`, default 32: data width.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset (0 = reset asserted).
- `a_valid`  in  1  requester A has a write pending.
- `a_ready`  out  1  A's request is accepted this cycle.
- `a_reg`  in  AW  A's destination register.
- `a_data`  in  DW  A's write data.
- `b_valid`  in  1  requester B has a write pending.
- `b_ready`  out  1  B's request is accepted this cycle.
- `b_reg`  in  AW  B's destination register.
- `b_data`  in  DW  B's write data.
- `wReg`  out  AW  write register number to `rf`, registered.
- `data`  out  DW  write data to `rf`, registered.
- `RegWrite`  out  1  write enable to `rf`, registered.
- `grant_b`  out  1  registered; 1 = current `RegWrite` cycle carries B's write, 0 = A's or a clear write.
- `busy`  out  1  1 while the clear sequence runs.

## Operation
- States: CLEAR and RUN. Reset forces CLEAR, clear counter `clr_cnt` = 0, round-robin pointer `last` = B (so A wins the first tie).
- CLEAR: on each edge, `wReg` <= `clr_cnt`, `data` <= 0, `RegWrite` <= 1, `grant_b` <= 0, and `clr_cnt` increments. On the edge where `clr_cnt` = `NREG`-1 is issued, the state moves to RUN. `a_ready` = `b_ready` = 0 and `busy` = 1 throughout CLEAR.
- RUN, `busy` = 0. The ready signals are combinational:
  - `a_ready` = `a_valid` && (!`b_valid` || `last` == B).
  - `b_ready` = `b_valid` && (!`a_valid` || `last` == A).
  - At most one ready is high per cycle.
- Transfer: `x_valid` && `x_ready` at an edge. That edge loads `wReg`/`data` from the winner, sets `RegWrite` = 1 and `grant_b` = (winner == B), and sets `last` = winner.
- No transfer: `RegWrite` <= 0, `grant_b` <= 0; `wReg`/`data` hold their values.
- A requester holds `valid`, `reg` and `data` stable until accepted. Dropping `valid` before acceptance is illegal.
- Both requesters writing the same register on consecutive grants: both writes issue in grant order, so the later write wins in `rf`. No merging.
- Register 0 is not special-cased and is writable.
- `x_reg` >= `NREG` is passed through unchanged; the requester owns range checking.

## Timing
- Reset values, applied immediately on assertion and independent of `clk`: `wReg` = 0, `data` = 0, `RegWrite` = 0, `grant_b` = 0, `busy` = 1, `a_ready` = `b_ready` = 0.
- Clear: `RegWrite` is high for exactly `NREG` consecutive cycles, starting at the first edge after reset release, with `wReg` = 0, 1, …, `NREG`-1.
- First cycle a ready can be high: immediately after the last clear edge.
- Latency: a request accepted at edge N appears on `wReg`/`data`/`RegWrite` after edge N and is written into `rf` at edge N+1.
- Throughput: one write per cycle. With both requesters continuously valid, grants strictly alternate.
- Reset asserted mid-CLEAR or mid-RUN aborts everything. An accepted write whose `RegWrite` cycle has not completed is lost, and the clear sequence restarts from register 0 after release.

## Structure
- Shared package `rf_pkg`: `NREG`/`AW`/`DW` defaults, state encoding (`ST_CLEAR`, `ST_RUN`), and the requester-id constants (`SRC_A` = 0, `SRC_B` = 1) used by `last` and `grant_b`.
- Sub-module `rr_arb2`: a two-way round-robin picker with inputs `req_a`, `req_b`, `last` and one-hot grant outputs, purely combinational. The pointer register stays in `rf_wr_arbiter`.
- Estimated size: about 150–200 RTL lines including `rr_arb2`.

## Test plan
- **Reset and clear:** `reset` low for 6 ns, then release. Outputs are at reset values while low. Then 32 cycles of `RegWrite` = 1 with `wReg` 0..31 and `data` = 0, then `busy` = 0. Reading all registers of `rf` returns 0.
- **Single requester:** only A valid, writes `reg` k with `data` k*10 for k = 1..31, holding valid until ready. Each write appears one cycle after acceptance. `rf` read pairs (k, k+1) return k*10 and (k+1)*10.
- **Contention:** A and B both continuously valid (A: reg 3, data 111; B: reg 3, data 222). Grants alternate A, B, A, B…, with `grant_b` = 0, 1, 0, 1. `rf` reg 3 holds the value of the last granted requester.
- **Requests during clear:** `a_valid` = 1 from reset release. `a_ready` stays 0 for all 32 clear cycles. A's write issues on the first RUN cycle and is not overwritten by the clear.
- **Mid-operation reset:** reset asserted after 10 RUN-phase writes. `RegWrite` drops to 0 asynchronously without waiting for a clock edge. After release, the full 32-register clear repeats, and previously written registers read 0.
